// File: rtl/pack_poly_stream.sv
// Streaming coefficient packer: accepts d-bit compressed coefficients and emits
// the polynomial's ciphertext bytes LSB-first over a valid/ready byte stream.
module pack_poly_stream #(
    parameter int KYBER_N         = 256,
    parameter int COEFF_WIDTH_MAX = 11,
    parameter int ACC_WIDTH       = COEFF_WIDTH_MAX + 7,
    parameter int CNT_WIDTH       = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [3:0]                 i_D,
    input  logic [COEFF_WIDTH_MAX-1:0] iCoeff,
    input  logic                       i_CoeffValid,
    output logic                       o_CoeffReady,
    output logic [7:0]                 o_Ciphertext,
    output logic                       o_CtValid,
    input  logic                       i_CtReady,
    output logic                       o_CtLast,
    output logic                       o_Busy
);

    localparam int                   NW    = $clog2(KYBER_N + 1);
    localparam logic [3:0]           DMAX  = 4'(COEFF_WIDTH_MAX);
    localparam logic [CNT_WIDTH-1:0] C8    = CNT_WIDTH'(8);
    localparam logic [NW-1:0]        NLAST = NW'(KYBER_N);

    typedef enum logic [1:0] {IDLE, PACK, FLUSH} state_t;

    state_t               state;
    logic [ACC_WIDTH-1:0] acc;
    logic [CNT_WIDTH-1:0] cnt;
    logic [NW-1:0]        ncoef;
    logic [3:0]           d_r;

    logic [3:0]           d_in;
    logic [3:0]           d_use;
    logic [ACC_WIDTH-1:0] mask;
    logic [ACC_WIDTH-1:0] coeff_sh;
    logic [CNT_WIDTH-1:0] cnt_dec;
    logic [NW-1:0]        ncoef_nxt;
    logic                 valid_i;
    logic                 last_i;
    logic                 cready_i;
    logic                 c_acc;
    logic                 b_acc;

    // Width is only taken from i_D on the first coefficient; illegal widths fall back to the maximum.
    assign d_in      = (i_D == 4'd0 || i_D > DMAX) ? DMAX : i_D;
    assign d_use     = (state == IDLE) ? d_in : d_r;
    assign mask      = (ACC_WIDTH'(1) << d_use) - ACC_WIDTH'(1);
    assign coeff_sh  = (ACC_WIDTH'(iCoeff) & mask) << cnt;
    assign cnt_dec   = (cnt >= C8) ? cnt - C8 : '0;
    assign ncoef_nxt = ncoef + NW'(1);

    assign valid_i  = (cnt >= C8) || (state == FLUSH && cnt != '0);
    assign last_i   = valid_i && state == FLUSH && cnt <= C8;
    assign cready_i = (state != FLUSH) && (cnt < C8);
    assign c_acc    = i_CoeffValid && cready_i;
    assign b_acc    = valid_i && i_CtReady;

    assign o_CoeffReady = !rst && cready_i;
    assign o_CtValid    = !rst && valid_i;
    assign o_CtLast     = !rst && last_i;
    assign o_Ciphertext = rst ? 8'h00 : acc[7:0];
    assign o_Busy       = !rst && (state != IDLE);

    // c_acc and b_acc never coincide: one needs cnt<8, the other cnt>=8 or FLUSH.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc   <= '0;
            cnt   <= '0;
            ncoef <= '0;
            d_r   <= 4'd1;
            state <= IDLE;
        end else if (c_acc) begin
            acc   <= acc | coeff_sh;
            cnt   <= cnt + CNT_WIDTH'(d_use);
            ncoef <= ncoef_nxt;
            if (state == IDLE)
                d_r <= d_in;
            state <= (ncoef_nxt == NLAST) ? FLUSH : PACK;
        end else if (b_acc) begin
            acc <= acc >> 8;
            cnt <= cnt_dec;
            if (state == FLUSH && cnt_dec == '0) begin
                state <= IDLE;
                ncoef <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pack_poly_stream.sv
// Directed bench for pack_poly_stream: small table-driven polynomials on N=8/N=3
// instances plus full-size N=256 sequences for stall, width latch and reset.
module tb_pack_poly_stream;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  i_D;
    logic [10:0] iCoeff;
    logic        i_CoeffValid;
    logic        i_CtReady;

    logic       cr8, cv8, cl8, bz8, cr3, cv3, cl3, bz3, crb, cvb, clb, bzb;
    logic [7:0] ct8, ct3, ctb;
    logic       cr, cv, cl, bz;
    logic [7:0] ct;
    int         sel;

    int nchk = 0;
    int nerr = 0;

    logic [10:0] coef [256];
    logic [7:0]  got [$];
    logic        lastq [$];
    logic [7:0]  nostall [$];

    always #5 clk = ~clk;

    pack_poly_stream #(.KYBER_N(8)) u_n8 (
        .clk(clk), .rst(rst), .i_D(i_D), .iCoeff(iCoeff), .i_CoeffValid(i_CoeffValid),
        .o_CoeffReady(cr8), .o_Ciphertext(ct8), .o_CtValid(cv8), .i_CtReady(i_CtReady),
        .o_CtLast(cl8), .o_Busy(bz8));

    pack_poly_stream #(.KYBER_N(3)) u_n3 (
        .clk(clk), .rst(rst), .i_D(i_D), .iCoeff(iCoeff), .i_CoeffValid(i_CoeffValid),
        .o_CoeffReady(cr3), .o_Ciphertext(ct3), .o_CtValid(cv3), .i_CtReady(i_CtReady),
        .o_CtLast(cl3), .o_Busy(bz3));

    pack_poly_stream #(.KYBER_N(256)) u_n256 (
        .clk(clk), .rst(rst), .i_D(i_D), .iCoeff(iCoeff), .i_CoeffValid(i_CoeffValid),
        .o_CoeffReady(crb), .o_Ciphertext(ctb), .o_CtValid(cvb), .i_CtReady(i_CtReady),
        .o_CtLast(clb), .o_Busy(bzb));

    always_comb begin
        case (sel)
            8:       begin cr = cr8; ct = ct8; cv = cv8; cl = cl8; bz = bz8; end
            3:       begin cr = cr3; ct = ct3; cv = cv3; cl = cl3; bz = bz3; end
            default: begin cr = crb; ct = ctb; cv = cvb; cl = clb; bz = bzb; end
        endcase
    end

    typedef struct packed {
        logic [8:0]        n;
        logic [3:0]        d;
        logic [7:0][10:0]  c;
        logic [2:0]        nb;
        logic [4:0][7:0]   b;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent bit-stream model: byte j collects stream bits 8j..8j+7 (N=256).
    function automatic logic [7:0] ref_byte(input int j, input int d);
        logic [7:0] r;
        r = 8'h00;
        for (int b = 0; b < 8; b++) begin
            int p;
            int k;
            p = 8 * j + b;
            k = p / d;
            if (k < 256) r[b] = coef[k][p % d];
        end
        return r;
    endfunction

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drives coefficients and collects bytes one cycle at a time; optional 5-cycle stall.
    task automatic run_poly(input int lim, input int n, input logic [3:0] dfirst,
                            input logic [3:0] dlater, input int stall_at);
        int ci = 0;
        int cyc = 0;
        int left = 0;
        bit started = 0;
        bit done = 0;
        bit prev = 0;
        logic [7:0] pb;
        logic pl;
        pb = 8'h00;
        pl = 1'b0;
        got.delete();
        lastq.delete();
        while (!done && cyc < 6000) begin
            i_CoeffValid = (ci < lim);
            iCoeff = (ci < 256) ? coef[ci] : 11'd0;
            i_D = (ci == 0) ? dfirst : dlater;
            #1;
            if (!started && stall_at >= 0 && cyc >= stall_at && cv) begin
                started = 1;
                left = 5;
            end
            i_CtReady = (left == 0);
            if (left > 0) left--;
            if (prev) begin
                chk("stall byte", ct, pb);
                chk("stall valid", cv, 1);
                chk("stall last", cl, pl);
            end
            if (cv && !i_CtReady) chk("stall coeff_ready", cr, 0);
            prev = cv && !i_CtReady;
            pb = ct;
            pl = cl;
            if (cv && i_CtReady) begin
                got.push_back(ct);
                lastq.push_back(cl);
                if (cl) done = 1;
            end
            if (i_CoeffValid && cr) begin
                ci++;
                if (lim < n && ci == lim) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        i_CoeffValid = 1'b0;
        i_CtReady = 1'b1;
        if (!done) begin
            nchk++;
            nerr++;
            $display("FAIL run timeout: got %0d bytes after %0d cycles", got.size(), cyc);
        end
    endtask

    task automatic check_last(input string name);
        int nl = 0;
        foreach (lastq[j]) if (lastq[j]) nl++;
        chk({name, " last count"}, nl, 1);
        if (lastq.size() > 0) chk({name, " last on final"}, lastq[lastq.size()-1], 1);
        chk({name, " busy after"}, bz, 0);
    endtask

    task automatic check_poly(input string name, input int d, input int nb);
        int bad = -1;
        chk({name, " count"}, got.size(), nb);
        foreach (got[j]) if (bad < 0 && got[j] !== ref_byte(j, d)) bad = j;
        nchk++;
        if (bad >= 0) begin
            nerr++;
            $display("FAIL %s bytes: byte %0d got %02h expected %02h", name, bad, got[bad], ref_byte(bad, d));
        end
        check_last(name);
    endtask

    initial begin
        tbl[0] = '{n: 9'd8, d: 4'd3, c: {11'd0, 11'd7, 11'd6, 11'd5, 11'd4, 11'd3, 11'd2, 11'd1},
                   nb: 3'd3, b: {8'h00, 8'h00, 8'h1F, 8'h58, 8'hD1}};
        tbl[1] = '{n: 9'd3, d: 4'd3, c: {55'd0, 11'd7, 11'd7, 11'd7},
                   nb: 3'd2, b: {24'd0, 8'h01, 8'hFF}};
        tbl[2] = '{n: 9'd8, d: 4'd3, c: {8{11'd7}},
                   nb: 3'd3, b: {16'd0, 8'hFF, 8'hFF, 8'hFF}};
        tbl[3] = '{n: 9'd8, d: 4'd3, c: {11'h7F8, 11'h3FF, 11'h0F6, 11'h00D, 11'h7FC, 11'h0AB, 11'h402, 11'h7F9},
                   nb: 3'd3, b: {8'h00, 8'h00, 8'h1F, 8'h58, 8'hD1}};
        tbl[4] = '{n: 9'd3, d: 4'd11, c: {55'd0, 11'h7FF, 11'h000, 11'h7FF},
                   nb: 3'd5, b: {8'h01, 8'hFF, 8'hC0, 8'h07, 8'hFF}};
        tbl[5] = '{n: 9'd3, d: 4'd0, c: {55'd0, 11'h7FF, 11'h000, 11'h7FF},
                   nb: 3'd5, b: {8'h01, 8'hFF, 8'hC0, 8'h07, 8'hFF}};
        tbl[6] = '{n: 9'd3, d: 4'd1, c: {55'd0, 11'd1, 11'd0, 11'd1},
                   nb: 3'd1, b: {32'd0, 8'h05}};

        sel = 256;
        rst = 1'b1;
        i_D = 4'd3;
        iCoeff = '0;
        i_CoeffValid = 1'b0;
        i_CtReady = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset coeff_ready", cr, 0);
        chk("reset ct_valid", cv, 0);
        chk("reset ct_last", cl, 0);
        chk("reset ciphertext", ct, 0);
        rst = 1'b0;
        #1;
        chk("post-reset coeff_ready", cr, 1);
        chk("post-reset ct_valid", cv, 0);
        chk("post-reset busy", bz, 0);

        for (int i = 0; i < 7; i++) begin
            sel = int'(tbl[i].n);
            for (int k = 0; k < 256; k++) coef[k] = (k < 8) ? tbl[i].c[k] : 11'd0;
            pulse_reset();
            run_poly(sel, sel, tbl[i].d, tbl[i].d, -1);
            chk($sformatf("vec%0d count", i), got.size(), int'(tbl[i].nb));
            for (int j = 0; j < int'(tbl[i].nb) && j < got.size(); j++)
                chk($sformatf("vec%0d byte%0d", i, j), got[j], tbl[i].b[j]);
            check_last($sformatf("vec%0d", i));
        end

        sel = 256;
        for (int k = 0; k < 256; k++) coef[k] = 11'd0;
        coef[0] = 11'h3FF;
        pulse_reset();
        run_poly(256, 256, 4'd10, 4'd10, -1);
        if (got.size() >= 2) begin
            chk("d10 byte0", got[0], 8'hFF);
            chk("d10 byte1", got[1], 8'h03);
        end
        check_poly("d10 single", 10, 320);

        for (int k = 0; k < 256; k++) coef[k] = 11'($urandom);
        pulse_reset();
        run_poly(256, 256, 4'd10, 4'd10, -1);
        check_poly("d10 nostall", 10, 320);
        nostall = got;
        pulse_reset();
        run_poly(256, 256, 4'd10, 4'd10, 20);
        check_poly("d10 stall", 10, 320);
        begin
            int bad = -1;
            foreach (got[j]) if (bad < 0 && (j >= nostall.size() || got[j] !== nostall[j])) bad = j;
            chk("stall vs nostall first diff", bad, -1);
        end

        pulse_reset();
        run_poly(256, 256, 4'd4, 4'd11, -1);
        check_poly("latch d4", 4, 128);
        run_poly(256, 256, 4'd0, 4'd0, -1);
        check_poly("coerce d0", 11, 352);

        pulse_reset();
        run_poly(50, 256, 4'd10, 4'd10, -1);
        rst = 1'b1;
        #1;
        chk("mid reset coeff_ready", cr, 0);
        chk("mid reset ct_valid", cv, 0);
        chk("mid reset ct_last", cl, 0);
        chk("mid reset ciphertext", ct, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("after mid reset coeff_ready", cr, 1);
        chk("after mid reset ct_valid", cv, 0);
        chk("after mid reset busy", bz, 0);
        for (int k = 0; k < 256; k++) coef[k] = 11'($urandom);
        run_poly(256, 256, 4'd5, 4'd5, -1);
        check_poly("after reset d5", 5, 160);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/pack_poly_stream.md
Name: pack_poly_stream

Overview:
- Streaming, parametrised successor to the fixed 3-bit, 8-to-3 combinational coefficient packer.
- Accepts one compressed polynomial coefficient per handshake and emits ciphertext bytes LSB-first over a valid/ready stream. Coefficient bit-width d is selectable per polynomial at run time, covering the du, dv and 3-bit packing paths.
- Sits between the compress stage and the ciphertext byte buffer in the encryption datapath.

Parameters:
KYBER_N, 256, coefficients per polynomial
COEFF_WIDTH_MAX, 11, maximum d and width of iCoeff
ACC_WIDTH, COEFF_WIDTH_MAX+7, bit-accumulator width
CNT_WIDTH, 5, width of accumulator fill counter (holds 0..ACC_WIDTH)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_D  in  4  coefficient width d; sampled on the first accepted coefficient of each polynomial
iCoeff  in  COEFF_WIDTH_MAX  compressed coefficient; only bits [d-1:0] are used
i_CoeffValid  in  1  iCoeff valid
o_CoeffReady  out  1  block can accept iCoeff this cycle
o_Ciphertext  out  8  packed output byte
o_CtValid  out  1  o_Ciphertext valid
i_CtReady  in  1  downstream accepts byte
o_CtLast  out  1  marks the final byte of the current polynomial
o_Busy  out  1  a polynomial is in progress (state != IDLE)

Behaviour:
- Registers: acc[ACC_WIDTH-1:0], fill count cnt, coefficient counter ncoef (0..KYBER_N), latched width d_r, state.
- Reset (rst=1 at clk edge): acc=0, cnt=0, ncoef=0, d_r=1, state=IDLE. While rst is high: o_CoeffReady=0, o_CtValid=0, o_CtLast=0, o_Ciphertext=0. Reset mid-polynomial discards all partial data; no byte is emitted.
- Outputs are combinational from registers only. o_CtValid = (cnt>=8) || (state==FLUSH && cnt>0). o_Ciphertext = acc[7:0].
- o_CoeffReady = (state!=FLUSH) && (cnt<8). It never depends on i_CtReady.
- Coefficient accept (i_CoeffValid && o_CoeffReady):
  - acc |= (iCoeff & mask(d)) << cnt; cnt += d; ncoef += 1.
  - In IDLE, d is taken from i_D directly and latched into d_r.
  - i_D changes mid-polynomial are ignored.
  - Illegal i_D (0 or >COEFF_WIDTH_MAX) is coerced to COEFF_WIDTH_MAX.
- Byte accept (o_CtValid && i_CtReady): acc >>= 8 (zero fill); cnt = (cnt>=8) ? cnt-8 : 0. Unused high bits of the last byte are therefore zero padding.
- Coefficient accept and byte accept are mutually exclusive by construction (cnt<8 vs cnt>=8 in PACK). Throughput is therefore at most one transfer per cycle.
- States:
  - IDLE: ncoef=0, cnt=0. First coefficient accept goes to PACK. If KYBER_N==1, that accept goes straight to FLUSH.
  - PACK: the accept that makes ncoef==KYBER_N goes to FLUSH.
  - FLUSH: no coefficient accepted; drains remaining bytes. On the byte accept that leaves cnt==0, go to IDLE and clear ncoef.
- o_CtLast = o_CtValid && state==FLUSH && cnt<=8. It is held together with the byte while i_CtReady is low.
- Backpressure: while o_CtValid && !i_CtReady, o_Ciphertext and o_CtLast are stable.
- Total bytes per polynomial = ceil(KYBER_N*d/8). With KYBER_N=256 this is exactly 32*d and no padding occurs.
- Bit order: coefficient k occupies stream bits [k*d, k*d+d-1]; byte j = stream bits [8j, 8j+7].
- Accumulator never overflows: at most 7+COEFF_WIDTH_MAX bits are held.

Test Plan:
- Parity with legacy packer, KYBER_N=8, i_D=3, coeffs 1,2,3,4,5,6,7,0, i_CtReady=1 -> bytes 0xD1, 0x58, 0x1F; o_CtLast only on 0x1F; o_Busy low after it.
- KYBER_N=256, i_D=10, coeff0=0x3FF, all others 0 -> 320 bytes; byte0=0xFF, byte1=0x03, rest 0x00; o_CtLast on byte 319 only.
- Padding, KYBER_N=3, i_D=3, coeffs 7,7,7 -> bytes 0xFF, 0x01 (upper 7 bits zero); o_CtLast on the second byte.
- Backpressure: i_CtReady low for 5 cycles mid-stream -> o_Ciphertext and o_CtValid stable; o_CoeffReady low while cnt>=8; output byte sequence identical to the no-stall run.
- Mode latch/coercion: i_D changed 4->11 after coeff 0 -> whole polynomial packed with d=4 (128 bytes for N=256). i_D=0 on a later polynomial -> packed as d=11 (352 bytes). Upper iCoeff bits above d are ignored.
- Reset mid-operation: rst high for 1 cycle after 50 coeffs -> all outputs 0 during reset, o_CoeffReady=1 next cycle, no stale byte emitted; the next polynomial packs correctly from coefficient 0.
